read_addr_arbiter: RTL and testbench

Read-address (AR) channel arbiter and sequencer for the AXI interconnect. It grants the shared AR path to one of two masters (M0, M1) round-robin and decodes the address to one of five slaves (S0–S4). It holds the grant until the granted master completes its read burst on the R channel, so the interconnect has exactly one read in flight. Unmapped addresses are answered by an internal default slave with DECERR beats, which the R-channel mux sees as an extra source.

---
 rtl/read_addr_arbiter_if.sv | 56 +++++
 rtl/read_addr_arbiter.sv | 157 +++++++++++++++
 tb/tb_read_addr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_addr_arbiter_if.sv
// AR request/grant and default-slave R bundle shared by the read-address arbiter.
// The slave modport is the arbiter's view; the master modport is the masters/slaves around it.
interface read_addr_arbiter_if #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]   ARID_M0,    ARID_M1;
  logic [ADDR_W-1:0] ARADDR_M0,  ARADDR_M1;
  logic [3:0]        ARLEN_M0,   ARLEN_M1;
  logic [2:0]        ARSIZE_M0,  ARSIZE_M1;
  logic [1:0]        ARBURST_M0, ARBURST_M1;
  logic              ARVALID_M0, ARVALID_M1;
  logic              ARREADY_M0, ARREADY_M1;
  logic              RVALID_M0,  RVALID_M1;
  logic              RREADY_M0,  RREADY_M1;
  logic              RLAST_M0,   RLAST_M1;

  logic [IDS_W-1:0]  ARID_S;
  logic [ADDR_W-1:0] ARADDR_S;
  logic [3:0]        ARLEN_S;
  logic [2:0]        ARSIZE_S;
  logic [1:0]        ARBURST_S;
  logic [4:0]        ARVALID_S;
  logic [4:0]        ARREADY_S;

  logic [IDS_W-1:0]  RID_DEF;
  logic [DATA_W-1:0] RDATA_DEF;
  logic [1:0]        RRESP_DEF;
  logic              RLAST_DEF;
  logic              RVALID_DEF;
  logic              RREADY_DEF;

  modport slave (
    input  ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
    input  ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
    output ARREADY_M0, ARREADY_M1,
    input  RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    output RID_DEF, RDATA_DEF, RRESP_DEF, RLAST_DEF, RVALID_DEF,
    input  RREADY_DEF
  );

  modport master (
    output ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
    output ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
    input  ARREADY_M0, ARREADY_M1,
    output RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    input  RID_DEF, RDATA_DEF, RRESP_DEF, RLAST_DEF, RVALID_DEF,
    output RREADY_DEF
  );
endinterface

// File: rtl/read_addr_arbiter.sv
// Two-master round-robin AR arbiter with five-slave decode and an internal DECERR slave.
// One read is in flight at a time: the grant is held until the burst's last R beat.
module read_addr_arbiter #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  read_addr_arbiter_if.slave  io_bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT_R, ST_DEF_R} state_t;

  // All regions are power-of-two sized and aligned, so decode is base/mask matching.
  localparam logic [ADDR_W-1:0] SLV_BASE [5] = '{
    ADDR_W'(32'h0000_0000), ADDR_W'(32'h0001_0000), ADDR_W'(32'h0002_0000),
    ADDR_W'(32'h1000_0000), ADDR_W'(32'h2000_0000)};
  localparam logic [ADDR_W-1:0] SLV_MASK [5] = '{
    ADDR_W'(32'h0000_3FFF), ADDR_W'(32'h0000_FFFF), ADDR_W'(32'h0000_FFFF),
    ADDR_W'(32'h0000_03FF), ADDR_W'(32'h001F_FFFF)};

  state_t            r_state;
  logic              r_last_grant;
  logic              r_gnt;
  logic [3:0]        r_beat_cnt;
  logic [IDS_W-1:0]  r_arid_s;
  logic [ADDR_W-1:0] r_araddr_s;
  logic [3:0]        r_arlen_s;
  logic [2:0]        r_arsize_s;
  logic [1:0]        r_arburst_s;
  logic [4:0]        r_arvalid_s;
  logic [IDS_W-1:0]  r_rid_def;
  logic [1:0]        r_rresp_def;
  logic              r_rlast_def;
  logic              r_rvalid_def;

  logic              w_idle;
  logic              w_gnt_m1;
  logic              w_gnt_m0;
  logic              w_take;
  logic [ADDR_W-1:0] w_addr;
  logic [ID_W-1:0]   w_id;
  logic [3:0]        w_len;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [IDS_W-1:0]  w_tagged_id;
  logic [4:0]        w_hit;
  logic              w_mapped;
  logic              w_r_done;

  assign w_idle   = rst && (r_state == ST_IDLE);
  assign w_gnt_m1 = io_bus.ARVALID_M1 && (!io_bus.ARVALID_M0 || !r_last_grant);
  assign w_gnt_m0 = io_bus.ARVALID_M0 && !w_gnt_m1;
  assign w_take   = w_idle && (io_bus.ARVALID_M0 || io_bus.ARVALID_M1);

  assign io_bus.ARREADY_M0 = w_idle && w_gnt_m0;
  assign io_bus.ARREADY_M1 = w_idle && w_gnt_m1;

  assign w_addr      = w_gnt_m1 ? io_bus.ARADDR_M1  : io_bus.ARADDR_M0;
  assign w_id        = w_gnt_m1 ? io_bus.ARID_M1    : io_bus.ARID_M0;
  assign w_len       = w_gnt_m1 ? io_bus.ARLEN_M1   : io_bus.ARLEN_M0;
  assign w_size      = w_gnt_m1 ? io_bus.ARSIZE_M1  : io_bus.ARSIZE_M0;
  assign w_burst     = w_gnt_m1 ? io_bus.ARBURST_M1 : io_bus.ARBURST_M0;
  assign w_tagged_id = {(w_gnt_m1 ? 4'b0010 : 4'b0001), w_id};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dec
      assign w_hit[gi] = (w_addr & ~SLV_MASK[gi]) == SLV_BASE[gi];
    end
  endgenerate
  assign w_mapped = |w_hit;

  assign w_r_done = r_gnt ? (io_bus.RVALID_M1 && io_bus.RREADY_M1 && io_bus.RLAST_M1)
                          : (io_bus.RVALID_M0 && io_bus.RREADY_M0 && io_bus.RLAST_M0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_beat_cnt   <= '0;
      r_arid_s     <= '0;
      r_araddr_s   <= '0;
      r_arlen_s    <= '0;
      r_arsize_s   <= '0;
      r_arburst_s  <= '0;
      r_arvalid_s  <= '0;
      r_rid_def    <= '0;
      r_rresp_def  <= '0;
      r_rlast_def  <= 1'b0;
      r_rvalid_def <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_gnt        <= w_gnt_m1;
            r_last_grant <= w_gnt_m1;
            r_arid_s     <= w_tagged_id;
            r_araddr_s   <= w_addr;
            r_arlen_s    <= w_len;
            r_arsize_s   <= w_size;
            r_arburst_s  <= w_burst;
            if (w_mapped) begin
              r_arvalid_s <= w_hit;
              r_state     <= ST_ADDR;
            end else begin
              r_rvalid_def <= 1'b1;
              r_rresp_def  <= 2'b11;
              r_rid_def    <= w_tagged_id;
              r_rlast_def  <= (w_len == 4'd0);
              r_beat_cnt   <= w_len;
              r_state      <= ST_DEF_R;
            end
          end
        end
        ST_ADDR: begin
          if (|(r_arvalid_s & io_bus.ARREADY_S)) begin
            r_arvalid_s <= '0;
            r_state     <= ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (w_r_done) r_state <= ST_IDLE;
        end
        ST_DEF_R: begin
          if (r_rvalid_def && io_bus.RREADY_DEF) begin
            if (r_rlast_def) begin
              r_rvalid_def <= 1'b0;
              r_rlast_def  <= 1'b0;
              r_rresp_def  <= '0;
              r_rid_def    <= '0;
              r_state      <= ST_IDLE;
            end else begin
              r_beat_cnt  <= r_beat_cnt - 4'd1;
              r_rlast_def <= (r_beat_cnt == 4'd1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.ARID_S     = r_arid_s;
  assign io_bus.ARADDR_S   = r_araddr_s;
  assign io_bus.ARLEN_S    = r_arlen_s;
  assign io_bus.ARSIZE_S   = r_arsize_s;
  assign io_bus.ARBURST_S  = r_arburst_s;
  assign io_bus.ARVALID_S  = r_arvalid_s;
  assign io_bus.RID_DEF    = r_rid_def;
  assign io_bus.RDATA_DEF  = {DATA_W{1'b0}};
  assign io_bus.RRESP_DEF  = r_rresp_def;
  assign io_bus.RLAST_DEF  = r_rlast_def;
  assign io_bus.RVALID_DEF = r_rvalid_def;
endmodule

// File: tb/tb_read_addr_arbiter.sv
// Directed bench for read_addr_arbiter: arbitration, decode, slave stall, DECERR bursts, reset.
module tb_read_addr_arbiter;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  read_addr_arbiter_if #(.ID_W(4), .IDS_W(8), .ADDR_W(32), .DATA_W(32)) bus ();

  read_addr_arbiter #(.ID_W(4), .IDS_W(8), .ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ARID_M0 = '0;    bus.ARID_M1 = '0;
    bus.ARADDR_M0 = '0;  bus.ARADDR_M1 = '0;
    bus.ARLEN_M0 = '0;   bus.ARLEN_M1 = '0;
    bus.ARSIZE_M0 = 3'd2; bus.ARSIZE_M1 = 3'd2;
    bus.ARBURST_M0 = 2'd1; bus.ARBURST_M1 = 2'd1;
    bus.ARVALID_M0 = 1'b0; bus.ARVALID_M1 = 1'b0;
    bus.RVALID_M0 = 1'b0; bus.RREADY_M0 = 1'b0; bus.RLAST_M0 = 1'b0;
    bus.RVALID_M1 = 1'b0; bus.RREADY_M1 = 1'b0; bus.RLAST_M1 = 1'b0;
    bus.ARREADY_S = '0;
    bus.RREADY_DEF = 1'b0;
  endtask

  task automatic r_beat(input bit m, input bit last);
    if (m) begin
      bus.RVALID_M1 = 1'b1; bus.RREADY_M1 = 1'b1; bus.RLAST_M1 = last;
    end else begin
      bus.RVALID_M0 = 1'b1; bus.RREADY_M0 = 1'b1; bus.RLAST_M0 = last;
    end
  endtask

  task automatic r_clear();
    bus.RVALID_M0 = 1'b0; bus.RREADY_M0 = 1'b0; bus.RLAST_M0 = 1'b0;
    bus.RVALID_M1 = 1'b0; bus.RREADY_M1 = 1'b0; bus.RLAST_M1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.ARVALID_M0 = 1'b1;
    step();
    step();
    n_vec++; if (bus.ARREADY_M0 !== 1'b0) begin n_err++; $display("FAIL rst_arready_m0: got %b want 0", bus.ARREADY_M0); end
    n_vec++; if (bus.ARVALID_S !== 5'b0) begin n_err++; $display("FAIL rst_arvalid_s: got %b want 00000", bus.ARVALID_S); end
    n_vec++; if (bus.ARID_S !== 8'h00) begin n_err++; $display("FAIL rst_arid_s: got %h want 00", bus.ARID_S); end
    n_vec++; if (bus.ARADDR_S !== 32'h0) begin n_err++; $display("FAIL rst_araddr_s: got %h want 0", bus.ARADDR_S); end
    n_vec++; if ({bus.RVALID_DEF, bus.RLAST_DEF, bus.RRESP_DEF} !== 4'b0) begin n_err++; $display("FAIL rst_def: got %b want 0000", {bus.RVALID_DEF, bus.RLAST_DEF, bus.RRESP_DEF}); end
    bus.ARVALID_M0 = 1'b0;
    rst = 1'b1;
    step();
    $display("xact reset done");
  endtask

  task automatic test_tie_first();
    bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0001_0010; bus.ARID_M0 = 4'h5;
    bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0000_0100; bus.ARID_M1 = 4'hA;
    #1;
    n_vec++; if (bus.ARREADY_M0 !== 1'b1) begin n_err++; $display("FAIL tie_ready_m0: got %b want 1", bus.ARREADY_M0); end
    n_vec++; if (bus.ARREADY_M1 !== 1'b0) begin n_err++; $display("FAIL tie_ready_m1: got %b want 0", bus.ARREADY_M1); end
    step();
    bus.ARVALID_M0 = 1'b0;
    #1;
    n_vec++; if (bus.ARVALID_S !== 5'b00010) begin n_err++; $display("FAIL tie_arvalid_s: got %b want 00010", bus.ARVALID_S); end
    n_vec++; if (bus.ARID_S !== 8'h15) begin n_err++; $display("FAIL tie_arid_s: got %h want 15", bus.ARID_S); end
    n_vec++; if (bus.ARADDR_S !== 32'h0001_0010) begin n_err++; $display("FAIL tie_araddr_s: got %h want 00010010", bus.ARADDR_S); end
    n_vec++; if (bus.ARREADY_M1 !== 1'b0) begin n_err++; $display("FAIL tie_holdoff_addr: got %b want 0", bus.ARREADY_M1); end
    bus.ARREADY_S = 5'b00010;
    step();
    bus.ARREADY_S = 5'b0;
    #1;
    n_vec++; if (bus.ARVALID_S !== 5'b0) begin n_err++; $display("FAIL tie_arvalid_drop: got %b want 00000", bus.ARVALID_S); end
    n_vec++; if (bus.ARREADY_M1 !== 1'b0) begin n_err++; $display("FAIL tie_holdoff_wait: got %b want 0", bus.ARREADY_M1); end
    r_beat(1'b0, 1'b1);
    step();
    r_clear();
    #1;
    n_vec++; if (bus.ARREADY_M1 !== 1'b1) begin n_err++; $display("FAIL tie_next_grant_m1: got %b want 1", bus.ARREADY_M1); end
    bus.ARVALID_M1 = 1'b0;
    step();
    $display("xact tie M0 -> S1 done");
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_sel;
    logic [7:0] exp_id;
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0002_0000; bus.ARID_M0 = 4'h4;
    bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h2000_0000; bus.ARID_M1 = 4'hB;
    for (int k = 0; k < 4; k++) begin
      exp_sel = (k % 2 == 1) ? 5'b10000 : 5'b00100;
      exp_id  = (k % 2 == 1) ? 8'h2B : 8'h14;
      #1;
      n_vec++; if (bus.ARREADY_M0 !== (k % 2 == 0)) begin n_err++; $display("FAIL b2b_ready_m0[%0d]: got %b want %b", k, bus.ARREADY_M0, (k % 2 == 0)); end
      n_vec++; if (bus.ARREADY_M1 !== (k % 2 == 1)) begin n_err++; $display("FAIL b2b_ready_m1[%0d]: got %b want %b", k, bus.ARREADY_M1, (k % 2 == 1)); end
      step();
      #1;
      n_vec++; if (bus.ARVALID_S !== exp_sel) begin n_err++; $display("FAIL b2b_arvalid_s[%0d]: got %b want %b", k, bus.ARVALID_S, exp_sel); end
      n_vec++; if (bus.ARID_S !== exp_id) begin n_err++; $display("FAIL b2b_arid_s[%0d]: got %h want %h", k, bus.ARID_S, exp_id); end
      bus.ARREADY_S = exp_sel;
      step();
      bus.ARREADY_S = 5'b0;
      r_beat(k % 2 == 1, 1'b1);
      step();
      r_clear();
      $display("xact b2b grant %0d to M%0d", k, k % 2);
    end
    bus.ARVALID_M0 = 1'b0;
    bus.ARVALID_M1 = 1'b0;
    step();
  endtask

  task automatic test_slave_stall();
    bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h1000_0000; bus.ARID_M1 = 4'h3; bus.ARLEN_M1 = 4'd2;
    #1;
    n_vec++; if (bus.ARREADY_M1 !== 1'b1) begin n_err++; $display("FAIL stall_ready_m1: got %b want 1", bus.ARREADY_M1); end
    step();
    bus.ARVALID_M1 = 1'b0;
    bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0000_0000; bus.ARID_M0 = 4'h7;
    for (int i = 0; i < 4; i++) begin
      bus.ARREADY_S = (i == 3) ? 5'b01000 : ((i == 1) ? 5'b00001 : 5'b00000);
      #1;
      n_vec++; if (bus.ARVALID_S !== 5'b01000) begin n_err++; $display("FAIL stall_arvalid_s[%0d]: got %b want 01000", i, bus.ARVALID_S); end
      n_vec++; if (bus.ARADDR_S !== 32'h1000_0000) begin n_err++; $display("FAIL stall_araddr_s[%0d]: got %h want 10000000", i, bus.ARADDR_S); end
      n_vec++; if (bus.ARLEN_S !== 4'd2) begin n_err++; $display("FAIL stall_arlen_s[%0d]: got %0d want 2", i, bus.ARLEN_S); end
      n_vec++; if (bus.ARID_S !== 8'h23) begin n_err++; $display("FAIL stall_arid_s[%0d]: got %h want 23", i, bus.ARID_S); end
      n_vec++; if (bus.ARREADY_M0 !== 1'b0) begin n_err++; $display("FAIL stall_holdoff_m0[%0d]: got %b want 0", i, bus.ARREADY_M0); end
      step();
    end
    bus.ARREADY_S = 5'b0;
    #1;
    n_vec++; if (bus.ARVALID_S !== 5'b0) begin n_err++; $display("FAIL stall_arvalid_drop: got %b want 00000", bus.ARVALID_S); end
    for (int b = 0; b < 3; b++) begin
      r_beat(1'b1, b == 2);
      #1;
      n_vec++; if (bus.ARREADY_M0 !== 1'b0) begin n_err++; $display("FAIL stall_wait_m0[%0d]: got %b want 0", b, bus.ARREADY_M0); end
      step();
    end
    r_clear();
    #1;
    n_vec++; if (bus.ARREADY_M0 !== 1'b1) begin n_err++; $display("FAIL stall_release_m0: got %b want 1", bus.ARREADY_M0); end
    bus.ARVALID_M0 = 1'b0;
    bus.ARLEN_M1 = 4'd0;
    step();
    $display("xact M1 -> S3 with 3-cycle stall done");
  endtask

  task automatic test_wrong_master();
    bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0000_3FFC; bus.ARID_M0 = 4'h1;
    #1;
    n_vec++; if (bus.ARREADY_M0 !== 1'b1) begin n_err++; $display("FAIL wm_ready_m0: got %b want 1", bus.ARREADY_M0); end
    step();
    bus.ARVALID_M0 = 1'b0;
    #1;
    n_vec++; if (bus.ARVALID_S !== 5'b00001) begin n_err++; $display("FAIL wm_arvalid_s: got %b want 00001", bus.ARVALID_S); end
    n_vec++; if (bus.ARID_S !== 8'h11) begin n_err++; $display("FAIL wm_arid_s: got %h want 11", bus.ARID_S); end
    bus.ARREADY_S = 5'b00001;
    step();
    bus.ARREADY_S = 5'b0;
    r_beat(1'b1, 1'b1);
    bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0000_0000;
    #1;
    n_vec++; if (bus.ARREADY_M1 !== 1'b0) begin n_err++; $display("FAIL wm_holdoff_a: got %b want 0", bus.ARREADY_M1); end
    step();
    r_clear();
    #1;
    n_vec++; if (bus.ARREADY_M1 !== 1'b0) begin n_err++; $display("FAIL wm_still_wait: got %b want 0", bus.ARREADY_M1); end
    r_beat(1'b0, 1'b1);
    step();
    r_clear();
    #1;
    n_vec++; if (bus.ARREADY_M1 !== 1'b1) begin n_err++; $display("FAIL wm_release: got %b want 1", bus.ARREADY_M1); end
    bus.ARVALID_M1 = 1'b0;
    step();
    $display("xact M0 -> S0 with foreign RLAST done");
  endtask

  task automatic test_default_burst();
    logic [4:0] pat;
    int beats;
    pat = 5'b11101;
    beats = 0;
    bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h3000_0000; bus.ARID_M0 = 4'h9; bus.ARLEN_M0 = 4'd3;
    #1;
    n_vec++; if (bus.ARREADY_M0 !== 1'b1) begin n_err++; $display("FAIL def_ready_m0: got %b want 1", bus.ARREADY_M0); end
    step();
    bus.ARVALID_M0 = 1'b0;
    bus.ARLEN_M0 = 4'd0;
    for (int c = 0; c < 5; c++) begin
      bus.RREADY_DEF = pat[c];
      #1;
      n_vec++; if (bus.RVALID_DEF !== 1'b1) begin n_err++; $display("FAIL def_rvalid[%0d]: got %b want 1", c, bus.RVALID_DEF); end
      n_vec++; if (bus.RLAST_DEF !== (beats == 3)) begin n_err++; $display("FAIL def_rlast[%0d]: got %b want %b", c, bus.RLAST_DEF, (beats == 3)); end
      if (pat[c]) begin
        beats++;
        n_vec++; if (bus.RRESP_DEF !== 2'b11) begin n_err++; $display("FAIL def_rresp[%0d]: got %b want 11", c, bus.RRESP_DEF); end
        n_vec++; if (bus.RID_DEF !== 8'h19) begin n_err++; $display("FAIL def_rid[%0d]: got %h want 19", c, bus.RID_DEF); end
        n_vec++; if (bus.RDATA_DEF !== 32'h0) begin n_err++; $display("FAIL def_rdata[%0d]: got %h want 0", c, bus.RDATA_DEF); end
      end
      n_vec++; if (bus.ARVALID_S !== 5'b0) begin n_err++; $display("FAIL def_arvalid_s[%0d]: got %b want 00000", c, bus.ARVALID_S); end
      step();
    end
    bus.RREADY_DEF = 1'b0;
    bus.ARVALID_M1 = 1'b1;
    #1;
    n_vec++; if (bus.RVALID_DEF !== 1'b0) begin n_err++; $display("FAIL def_done_rvalid: got %b want 0", bus.RVALID_DEF); end
    n_vec++; if (bus.ARREADY_M1 !== 1'b1) begin n_err++; $display("FAIL def_done_idle: got %b want 1", bus.ARREADY_M1); end
    bus.ARVALID_M1 = 1'b0;
    step();
    $display("xact M0 unmapped 4-beat DECERR done");
  endtask

  task automatic test_default_single();
    bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0000_4000; bus.ARID_M1 = 4'h2; bus.ARLEN_M1 = 4'd0;
    #1;
    n_vec++; if (bus.ARREADY_M1 !== 1'b1) begin n_err++; $display("FAIL def1_ready_m1: got %b want 1", bus.ARREADY_M1); end
    step();
    bus.ARVALID_M1 = 1'b0;
    bus.RREADY_DEF = 1'b1;
    #1;
    n_vec++; if (bus.RVALID_DEF !== 1'b1) begin n_err++; $display("FAIL def1_rvalid: got %b want 1", bus.RVALID_DEF); end
    n_vec++; if (bus.RLAST_DEF !== 1'b1) begin n_err++; $display("FAIL def1_rlast: got %b want 1", bus.RLAST_DEF); end
    n_vec++; if (bus.RID_DEF !== 8'h22) begin n_err++; $display("FAIL def1_rid: got %h want 22", bus.RID_DEF); end
    n_vec++; if (bus.ARVALID_S !== 5'b0) begin n_err++; $display("FAIL def1_arvalid_s: got %b want 00000", bus.ARVALID_S); end
    step();
    bus.RREADY_DEF = 1'b0;
    #1;
    n_vec++; if (bus.RVALID_DEF !== 1'b0) begin n_err++; $display("FAIL def1_done: got %b want 0", bus.RVALID_DEF); end
    step();
    $display("xact M1 unmapped single-beat DECERR done");
  endtask

  task automatic test_reset_mid_burst();
    bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h3000_0000; bus.ARID_M0 = 4'h6; bus.ARLEN_M0 = 4'd3;
    step();
    bus.ARVALID_M0 = 1'b0;
    bus.ARLEN_M0 = 4'd0;
    bus.RREADY_DEF = 1'b1;
    #1;
    n_vec++; if (bus.RVALID_DEF !== 1'b1) begin n_err++; $display("FAIL rmid_beat1: got %b want 1", bus.RVALID_DEF); end
    step();
    #1;
    n_vec++; if (bus.RLAST_DEF !== 1'b0) begin n_err++; $display("FAIL rmid_beat2_rlast: got %b want 0", bus.RLAST_DEF); end
    rst = 1'b0;
    step();
    n_vec++; if (bus.RVALID_DEF !== 1'b0) begin n_err++; $display("FAIL rmid_rvalid: got %b want 0", bus.RVALID_DEF); end
    n_vec++; if (bus.RID_DEF !== 8'h00) begin n_err++; $display("FAIL rmid_rid: got %h want 00", bus.RID_DEF); end
    n_vec++; if (bus.RRESP_DEF !== 2'b00) begin n_err++; $display("FAIL rmid_rresp: got %b want 00", bus.RRESP_DEF); end
    n_vec++; if (bus.ARID_S !== 8'h00) begin n_err++; $display("FAIL rmid_arid_s: got %h want 00", bus.ARID_S); end
    bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0001_0000; bus.ARID_M0 = 4'h1;
    bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0002_0000; bus.ARID_M1 = 4'h2;
    #1;
    n_vec++; if ({bus.ARREADY_M0, bus.ARREADY_M1} !== 2'b00) begin n_err++; $display("FAIL rmid_ready_in_rst: got %b want 00", {bus.ARREADY_M0, bus.ARREADY_M1}); end
    rst = 1'b1;
    bus.RREADY_DEF = 1'b0;
    #1;
    n_vec++; if (bus.ARREADY_M0 !== 1'b1) begin n_err++; $display("FAIL rmid_tie_m0: got %b want 1", bus.ARREADY_M0); end
    n_vec++; if (bus.ARREADY_M1 !== 1'b0) begin n_err++; $display("FAIL rmid_tie_m1: got %b want 0", bus.ARREADY_M1); end
    step();
    bus.ARVALID_M0 = 1'b0;
    bus.ARVALID_M1 = 1'b0;
    #1;
    n_vec++; if (bus.ARVALID_S !== 5'b00010) begin n_err++; $display("FAIL rmid_arvalid_s: got %b want 00010", bus.ARVALID_S); end
    n_vec++; if (bus.ARID_S !== 8'h11) begin n_err++; $display("FAIL rmid_arid_new: got %h want 11", bus.ARID_S); end
    bus.ARREADY_S = 5'b00010;
    step();
    bus.ARREADY_S = 5'b0;
    r_beat(1'b0, 1'b1);
    step();
    r_clear();
    $display("xact reset mid DECERR burst, then M0 -> S1 done");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_tie_first();
    test_back_to_back();
    test_slave_stall();
    test_wrong_master();
    test_default_burst();
    test_default_single();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
